// File: rtl/service_counter_bank_pkg.sv
// ----------------------------------------------------------------------------
// service_counter_bank_pkg
// Purpose : Shared definitions for the service counter bank. The ticket/time
//           width and counter count are kept here so the dispatcher and the
//           counter bank agree on them.
// Contents: DT_SZ    - width of ticket number and service time
//           CNTER    - number of service counters
//           srv_state_e - per-counter FSM encoding (idle = 0, serve = 1)
// ----------------------------------------------------------------------------
package service_counter_bank_pkg;

   localparam int unsigned DT_SZ = 4;
   localparam int unsigned CNTER = 3;

   typedef enum logic {
      StIdle  = 1'b0,
      StServe = 1'b1
   } srv_state_e;

endpackage

// File: rtl/service_counter.sv
// ----------------------------------------------------------------------------
// service_counter
// Purpose : One service counter. Latches a ticket and a service time on load,
//           then stays busy for max(dt,1)*TICK_DIV clock cycles, counting the
//           remaining time units down via a clock prescaler.
// Ports   : i_clk       clock, rising edge
//           i_rst       synchronous active-high reset
//           i_ld        load strobe for this counter
//           i_dn        ticket number, valid with i_ld
//           i_dt        service time in units, valid with i_ld
//           o_busy      counter is serving (registered state)
//           o_cur_n     ticket currently / last held
//           o_rem_t     remaining service units
//           o_done      1-cycle pulse after service completes (registered)
//           o_done_nxt  value o_done takes at the next edge (for served count)
//           o_ld_hit    load strobe arrived while serving (rejected)
// ----------------------------------------------------------------------------
module service_counter #(
   parameter int unsigned DT_SZ    = service_counter_bank_pkg::DT_SZ,
   parameter int unsigned TICK_DIV = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_ld,
   input  logic [DT_SZ-1:0] i_dn,
   input  logic [DT_SZ-1:0] i_dt,
   output logic             o_busy,
   output logic [DT_SZ-1:0] o_cur_n,
   output logic [DT_SZ-1:0] o_rem_t,
   output logic             o_done,
   output logic             o_done_nxt,
   output logic             o_ld_hit
);

   import service_counter_bank_pkg::*;

   // A one-bit prescaler is kept even for TICK_DIV == 1; it then never
   // leaves zero because PRE_MAX is zero.
   localparam int unsigned    PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

   srv_state_e       r_state;
   srv_state_e       w_state_nxt;
   logic [DT_SZ-1:0] r_cur_n;
   logic [DT_SZ-1:0] w_cur_n_nxt;
   logic [DT_SZ-1:0] r_rem_t;
   logic [DT_SZ-1:0] w_rem_t_nxt;
   logic [PRE_W-1:0] r_pre;
   logic [PRE_W-1:0] w_pre_nxt;
   logic             r_done;
   logic             w_done_nxt;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath registers that move together with the FSM
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cur_n <= '0;
         r_rem_t <= '0;
         r_pre   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_cur_n <= w_cur_n_nxt;
         r_rem_t <= w_rem_t_nxt;
         r_pre   <= w_pre_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cur_n_nxt = r_cur_n;
      w_rem_t_nxt = r_rem_t;
      w_pre_nxt   = r_pre;
      w_done_nxt  = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_ld) begin
               w_state_nxt = StServe;
               w_cur_n_nxt = i_dn;
               // A zero service time still occupies the counter for one unit.
               w_rem_t_nxt = (i_dt == '0) ? DT_SZ'(1) : i_dt;
               w_pre_nxt   = '0;
            end
         end
         StServe: begin
            // Loads while serving are rejected; only the time base advances.
            if (r_pre == PRE_MAX) begin
               w_pre_nxt = '0;
               if (r_rem_t == DT_SZ'(1)) begin
                  w_state_nxt = StIdle;
                  w_rem_t_nxt = '0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_rem_t_nxt = r_rem_t - DT_SZ'(1);
               end
            end else begin
               w_pre_nxt = r_pre + PRE_W'(1);
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   always_comb begin
      o_busy     = (r_state == StServe);
      o_cur_n    = r_cur_n;
      o_rem_t    = r_rem_t;
      o_done     = r_done;
      o_done_nxt = w_done_nxt;
      o_ld_hit   = i_ld && (r_state == StServe);
   end

endmodule

// File: rtl/service_counter_bank.sv
// ----------------------------------------------------------------------------
// service_counter_bank
// Purpose : Bank of CNTER service counters on the counter side of the
//           dispatcher interface. Accepts one-hot (or multi-hot) loads,
//           reports per-counter busy back to the dispatcher, and exposes the
//           ticket being served, completion pulses and a served-ticket total.
// Ports   : i_clk     clock, rising edge
//           i_rst     synchronous active-high reset
//           i_ld      per-counter load strobe
//           i_dn      ticket number, valid with i_ld
//           i_dt      service time in units, valid with i_ld
//           o_busy    per-counter serving flag
//           o_cur_n   ticket held by counter i at [i*DT_SZ +: DT_SZ]
//           o_rem_t   remaining units of counter i at [i*DT_SZ +: DT_SZ]
//           o_done    per-counter 1-cycle completion pulse
//           o_ld_err  1-cycle pulse: a load addressed a busy counter
//           o_served  total completed services, wraps at 2^CNT_W
// All outputs are registered.
// ----------------------------------------------------------------------------
module service_counter_bank #(
   parameter int unsigned DT_SZ    = service_counter_bank_pkg::DT_SZ,
   parameter int unsigned CNTER    = service_counter_bank_pkg::CNTER,
   parameter int unsigned TICK_DIV = 4,
   parameter int unsigned CNT_W    = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [CNTER-1:0]       i_ld,
   input  logic [DT_SZ-1:0]       i_dn,
   input  logic [DT_SZ-1:0]       i_dt,
   output logic [CNTER-1:0]       o_busy,
   output logic [CNTER*DT_SZ-1:0] o_cur_n,
   output logic [CNTER*DT_SZ-1:0] o_rem_t,
   output logic [CNTER-1:0]       o_done,
   output logic                   o_ld_err,
   output logic [CNT_W-1:0]       o_served
);

   import service_counter_bank_pkg::*;

   logic [CNTER-1:0] w_done_nxt;
   logic [CNTER-1:0] w_ld_hit;
   logic [CNT_W-1:0] w_done_cnt;
   logic             r_ld_err;
   logic [CNT_W-1:0] r_served;

   for (genvar g = 0; g < CNTER; g++) begin : g_ctr
      service_counter #(
         .DT_SZ    (DT_SZ),
         .TICK_DIV (TICK_DIV)
      ) u_ctr (
         .i_clk      (i_clk),
         .i_rst      (i_rst),
         .i_ld       (i_ld[g]),
         .i_dn       (i_dn),
         .i_dt       (i_dt),
         .o_busy     (o_busy[g]),
         .o_cur_n    (o_cur_n[g*DT_SZ +: DT_SZ]),
         .o_rem_t    (o_rem_t[g*DT_SZ +: DT_SZ]),
         .o_done     (o_done[g]),
         .o_done_nxt (w_done_nxt[g]),
         .o_ld_hit   (w_ld_hit[g])
      );
   end

   // Count completions from the next-done vector so the total updates in the
   // same cycle the done pulses appear.
   always_comb begin
      w_done_cnt = '0;
      for (int i = 0; i < CNTER; i++) begin
         w_done_cnt = w_done_cnt + CNT_W'(w_done_nxt[i]);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ld_err <= 1'b0;
         r_served <= '0;
      end else begin
         r_ld_err <= |w_ld_hit;
         r_served <= r_served + w_done_cnt;
      end
   end

   assign o_ld_err = r_ld_err;
   assign o_served = r_served;

endmodule
